// File: rtl/fp_wire_pkg.sv
// Shared types for the FP request path: the queued request payload and the
// issue-queue sequencer states.
package fp_wire_pkg;

    localparam int unsigned FP_DATA_W   = 64;
    localparam int unsigned FP_FLAGS_W  = 5;
    localparam int unsigned FP_FMT_W    = 2;
    localparam int unsigned FP_RM_W     = 3;
    localparam int unsigned FP_OP_W     = 2;
    localparam int unsigned FP_OPCODE_W = 10;

    // One queued FP operation (209 bits)
    typedef struct packed {
        logic [FP_DATA_W-1:0]   data1;
        logic [FP_DATA_W-1:0]   data2;
        logic [FP_DATA_W-1:0]   data3;
        logic [FP_FMT_W-1:0]    fmt;
        logic [FP_RM_W-1:0]     rm;
        logic [FP_OP_W-1:0]     op;
        logic [FP_OPCODE_W-1:0] opcode;
    } fp_iq_req_type;

    localparam int unsigned FP_IQ_REQ_W = $bits(fp_iq_req_type);

    typedef enum logic {
        IQ_IDLE = 1'b0,
        IQ_WAIT = 1'b1
    } fp_iq_state_type;

endpackage

// File: rtl/fp_issue_queue_if.sv
// Request, fp_unit and response ports of the FP issue queue; slave is the
// queue's view, master the environment's view.
interface fp_issue_queue_if;
    import fp_wire_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [FP_DATA_W-1:0]   req_data1;
    logic [FP_DATA_W-1:0]   req_data2;
    logic [FP_DATA_W-1:0]   req_data3;
    logic [FP_FMT_W-1:0]    req_fmt;
    logic [FP_RM_W-1:0]     req_rm;
    logic [FP_OP_W-1:0]     req_op;
    logic [FP_OPCODE_W-1:0] req_opcode;

    logic [FP_DATA_W-1:0]   exe_data1;
    logic [FP_DATA_W-1:0]   exe_data2;
    logic [FP_DATA_W-1:0]   exe_data3;
    logic [FP_FMT_W-1:0]    exe_fmt;
    logic [FP_RM_W-1:0]     exe_rm;
    logic [FP_OP_W-1:0]     exe_op;
    logic [FP_OPCODE_W-1:0] exe_opcode;
    logic                   exe_enable;
    logic [FP_DATA_W-1:0]   exe_result;
    logic [FP_FLAGS_W-1:0]  exe_flags;
    logic                   exe_ready;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [FP_DATA_W-1:0]   rsp_result;
    logic [FP_FLAGS_W-1:0]  rsp_flags;
    logic                   rsp_timeout;

    logic                   err_spurious;
    logic                   err_timeout;

    modport slave (
        input  req_valid, req_data1, req_data2, req_data3,
               req_fmt, req_rm, req_op, req_opcode,
        output req_ready,
        output exe_data1, exe_data2, exe_data3, exe_fmt, exe_rm, exe_op,
               exe_opcode, exe_enable,
        input  exe_result, exe_flags, exe_ready,
        output rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        input  rsp_ready,
        output err_spurious, err_timeout
    );

    modport master (
        output req_valid, req_data1, req_data2, req_data3,
               req_fmt, req_rm, req_op, req_opcode,
        input  req_ready,
        input  exe_data1, exe_data2, exe_data3, exe_fmt, exe_rm, exe_op,
               exe_opcode, exe_enable,
        output exe_result, exe_flags, exe_ready,
        input  rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        output rsp_ready,
        input  err_spurious, err_timeout
    );

endinterface

// File: rtl/fp_iq_fifo.sv
// In-order request FIFO for the FP issue queue; head is readable the cycle
// after an entry is written (no bypass).
module fp_iq_fifo
    import fp_wire_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  fp_iq_req_type         i_data,
    input  logic                  i_pop,
    output fp_iq_req_type         o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fp_iq_req_type    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Full blocks a push even when a pop happens in the same cycle
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fp_issue_queue.sv
// Buffers FP requests, issues them one at a time to fp_unit, and returns
// results in order with a completion timeout.
module fp_issue_queue
    import fp_wire_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    fp_issue_queue_if.slave  bus
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WCNT_W = $clog2(TIMEOUT);

    fp_iq_state_type       r_state;
    fp_iq_state_type       w_state_next;
    fp_iq_req_type         w_req;
    fp_iq_req_type         w_head;
    fp_iq_req_type         r_exe;
    logic                  r_exe_enable;
    logic [WCNT_W-1:0]     r_wait_cnt;
    logic                  r_rsp_valid;
    logic [FP_DATA_W-1:0]  r_rsp_result;
    logic [FP_FLAGS_W-1:0] r_rsp_flags;
    logic                  r_rsp_timeout;
    logic                  r_err_spurious;
    logic                  r_err_timeout;

    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic                  w_issue;
    logic                  w_complete;
    logic                  w_timeout;

    assign w_req = '{data1:  bus.req_data1,  data2: bus.req_data2,
                     data3:  bus.req_data3,  fmt:   bus.req_fmt,
                     rm:     bus.req_rm,     op:    bus.req_op,
                     opcode: bus.req_opcode};

    assign w_push        = bus.req_valid && !w_full;
    assign bus.req_ready = !w_full;

    fp_iq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_issue),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Issue only with no response held, so at most one op is in flight or held
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IQ_IDLE: begin
                if ((w_count != '0) && !r_rsp_valid) begin
                    w_issue      = 1'b1;
                    w_state_next = IQ_WAIT;
                end
            end
            IQ_WAIT: begin
                if (bus.exe_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = IQ_IDLE;
                end else if (r_wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = IQ_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IQ_IDLE;
        else       r_state <= w_state_next;
    end

    // Operands stay stable from issue until fp_unit completes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_exe        <= '0;
            r_exe_enable <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_exe_enable <= w_issue;
            if (w_issue) r_exe <= w_head;
            if (w_issue)                r_wait_cnt <= '0;
            else if (r_state == IQ_WAIT) r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b0;
        end else if (w_complete) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_result  <= bus.exe_result;
            r_rsp_flags   <= bus.exe_flags;
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_result  <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b1;
        end else if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_spurious <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            if (bus.exe_ready && (r_state != IQ_WAIT)) r_err_spurious <= 1'b1;
            if (w_timeout)                            r_err_timeout  <= 1'b1;
        end
    end

    assign bus.exe_data1    = r_exe.data1;
    assign bus.exe_data2    = r_exe.data2;
    assign bus.exe_data3    = r_exe.data3;
    assign bus.exe_fmt      = r_exe.fmt;
    assign bus.exe_rm       = r_exe.rm;
    assign bus.exe_op       = r_exe.op;
    assign bus.exe_opcode   = r_exe.opcode;
    assign bus.exe_enable   = r_exe_enable;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_flags    = r_rsp_flags;
    assign bus.rsp_timeout  = r_rsp_timeout;
    assign bus.err_spurious = r_err_spurious;
    assign bus.err_timeout  = r_err_timeout;

    a_empty_count : assert property (@(posedge clock) disable iff (reset)
        w_empty == (w_count == '0));

endmodule

// File: tb/tb_fp_issue_queue.sv
// Directed bench for fp_issue_queue with a behavioural fp_unit stub and a
// response logger.
module tb_fp_issue_queue;

    localparam int STUB_LAT = 1;

    logic clock;
    logic reset;

    fp_issue_queue_if bus ();

    fp_issue_queue #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic        stub_hang = 1'b0;
    int          spur_cnt  = 0;

    logic [63:0] log_res [0:31];
    logic [4:0]  log_flg [0:31];
    logic        log_to  [0:31];
    int          rsp_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stand-in for fp_unit: two hand-known IEEE cases, otherwise a+b
    function automatic void stub_model(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] c, input logic [9:0] opc,
                                       output logic [63:0] r, output logic [4:0] f);
        if (opc == 10'h002 && a[31:0] == 32'h3F800000 && b[31:0] == 32'h40000000) begin
            r = 64'h40400000; f = 5'b00000;
        end else if (opc == 10'h010 && b[30:0] == 31'h0) begin
            r = 64'h7F800000; f = 5'b01000;
        end else begin
            r = a + b; f = c[4:0];
        end
    endfunction

    initial begin : stub
        logic        busy;
        int          cnt;
        int          spur_seen;
        logic [63:0] d1, d2, d3, r;
        logic [9:0]  opc;
        logic [4:0]  f;
        busy = 1'b0; cnt = 0; spur_seen = 0;
        d1 = '0; d2 = '0; d3 = '0; opc = '0;
        bus.exe_ready  = 1'b0;
        bus.exe_result = '0;
        bus.exe_flags  = '0;
        forever begin
            @(negedge clock);
            bus.exe_ready = 1'b0;
            if (reset) begin
                busy = 1'b0;
            end else begin
                if (bus.exe_enable) begin
                    busy = 1'b1; cnt = STUB_LAT;
                    d1 = bus.exe_data1; d2 = bus.exe_data2; d3 = bus.exe_data3;
                    opc = bus.exe_opcode;
                end
                if (stub_hang) busy = 1'b0;
                if (busy) begin
                    if (cnt == 0) begin
                        busy = 1'b0;
                        stub_model(d1, d2, d3, opc, r, f);
                        bus.exe_ready  = 1'b1;
                        bus.exe_result = r;
                        bus.exe_flags  = f;
                    end else begin
                        cnt--;
                    end
                end else if (spur_seen != spur_cnt) begin
                    spur_seen      = spur_cnt;
                    bus.exe_ready  = 1'b1;
                    bus.exe_result = 64'hDEAD;
                    bus.exe_flags  = 5'h1F;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock);
            #1;
            if (bus.rsp_valid && bus.rsp_ready && rsp_cnt < 32) begin
                log_res[rsp_cnt] = bus.rsp_result;
                log_flg[rsp_cnt] = bus.rsp_flags;
                log_to[rsp_cnt]  = bus.rsp_timeout;
                rsp_cnt++;
            end
        end
    end

    task automatic drive_req(input logic [63:0] d1, input logic [63:0] d2,
                             input logic [63:0] d3, input logic [9:0] opc);
        bus.req_valid  = 1'b1;
        bus.req_data1  = d1;
        bus.req_data2  = d2;
        bus.req_data3  = d3;
        bus.req_fmt    = 2'd0;
        bus.req_rm     = 3'd0;
        bus.req_op     = 2'd0;
        bus.req_opcode = opc;
    endtask

    task automatic push_req(input logic [63:0] d1, input logic [63:0] d2,
                            input logic [63:0] d3, input logic [9:0] opc);
        int t;
        t = 0;
        drive_req(d1, d2, d3, opc);
        while (!bus.req_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        check_eq("push_ready", bus.req_ready, 1'b1);
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int t;
        t = 0;
        while (rsp_cnt < target && t < 300) begin
            @(negedge clock);
            t++;
        end
        check_eq("rsp_arrive", rsp_cnt >= target, 1'b1);
    endtask

    initial begin : main
        int base, accepted, blocked_at, t, n;
        logic released;

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_data1 = '0; bus.req_data2 = '0; bus.req_data3 = '0;
        bus.req_fmt = '0; bus.req_rm = '0; bus.req_op = '0; bus.req_opcode = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check_eq("rst_req_ready", bus.req_ready, 1'b1);
        check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("rst_exe_enable", bus.exe_enable, 1'b0);
        check_eq("rst_err_spur", bus.err_spurious, 1'b0);
        check_eq("rst_err_to", bus.err_timeout, 1'b0);
        check_eq("rst_rsp_result", bus.rsp_result, 64'h0);

        // fadd 1.0 + 2.0, best-case timing
        base = rsp_cnt;
        push_req(64'h3F800000, 64'h40000000, 64'h0, 10'h002);
        check_eq("lat_e0_enable", bus.exe_enable, 1'b0);
        @(negedge clock);
        check_eq("lat_e1_enable", bus.exe_enable, 1'b1);
        check_eq("exe_data1", bus.exe_data1, 64'h3F800000);
        check_eq("exe_opcode", bus.exe_opcode, 10'h002);
        @(negedge clock);
        check_eq("lat_e2_enable", bus.exe_enable, 1'b0);
        check_eq("exe_data2_hold", bus.exe_data2, 64'h40000000);
        check_eq("lat_e2_rsp", bus.rsp_valid, 1'b0);
        @(negedge clock);
        check_eq("lat_e3_rsp", bus.rsp_valid, 1'b1);
        wait_rsp(base + 1);
        check_eq("fadd_res", 64'(log_res[base][31:0]), 64'h40400000);
        check_eq("fadd_flags", log_flg[base], 5'b00000);
        check_eq("fadd_to", log_to[base], 1'b0);

        // fdiv 1.0 / 0.0
        base = rsp_cnt;
        push_req(64'h3F800000, 64'h00000000, 64'h0, 10'h010);
        wait_rsp(base + 1);
        check_eq("fdiv_res", 64'(log_res[base][31:0]), 64'h7F800000);
        check_eq("fdiv_flags", log_flg[base], 5'b01000);
        check_eq("fdiv_to", log_to[base], 1'b0);

        // Back-pressure: 1 held + 4 queued before req_ready drops
        base = rsp_cnt;
        bus.rsp_ready = 1'b0;
        accepted = 0; blocked_at = -1; released = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_req(64'h1000 + 64'(i), 64'h20, 64'(i), 10'h008);
            t = 0;
            while (!bus.req_ready && t < 200) begin
                if (!released) begin
                    blocked_at = accepted;
                    repeat (10) @(negedge clock);
                    check_eq("full_hold", bus.req_ready, 1'b0);
                    check_eq("held_rsp", bus.rsp_valid, 1'b1);
                    bus.rsp_ready = 1'b1;
                    released = 1'b1;
                end else begin
                    @(negedge clock);
                    t++;
                end
            end
            check_eq("fill_ready", bus.req_ready, 1'b1);
            @(negedge clock);
            accepted++;
        end
        bus.req_valid = 1'b0;
        check_eq("fill_block_at", 64'(blocked_at), 64'd5);
        wait_rsp(base + 8);
        for (int i = 0; i < 8; i++) begin
            check_eq("fill_res", log_res[base + i], 64'h1020 + 64'(i));
            check_eq("fill_flags", 64'(log_flg[base + i]), 64'(i));
        end

        // Spurious completion while idle
        base = rsp_cnt;
        spur_cnt++;
        repeat (4) @(negedge clock);
        check_eq("spur_err", bus.err_spurious, 1'b1);
        check_eq("spur_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("spur_no_log", 64'(rsp_cnt), 64'(base));

        // Timeout abort after 16 WAIT cycles
        base = rsp_cnt;
        stub_hang = 1'b1;
        bus.rsp_ready = 1'b0;
        push_req(64'h5, 64'h6, 64'h0, 10'h008);
        t = 0;
        while (!bus.exe_enable && t < 20) begin
            @(negedge clock);
            t++;
        end
        check_eq("to_issue", bus.exe_enable, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check_eq("to_cycles", 64'(n), 64'd16);
        check_eq("to_flag", bus.rsp_timeout, 1'b1);
        check_eq("to_result", bus.rsp_result, 64'h0);
        check_eq("to_flags", bus.rsp_flags, 5'h0);
        check_eq("to_err", bus.err_timeout, 1'b1);
        stub_hang = 1'b0;
        push_req(64'h100, 64'h23, 64'h3, 10'h008);
        bus.rsp_ready = 1'b1;
        wait_rsp(base + 2);
        check_eq("to_log_flag", log_to[base], 1'b1);
        check_eq("after_to_res", log_res[base + 1], 64'h123);
        check_eq("after_to_flag", log_to[base + 1], 1'b0);

        // Reset while WAIT with three queued
        stub_hang = 1'b1;
        for (int i = 0; i < 4; i++) push_req(64'h40 + 64'(i), 64'h1, 64'h0, 10'h008);
        check_eq("pre_rst_count", 64'(dut.w_count), 64'd3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("mid_rst_count", 64'(dut.w_count), 64'd0);
        check_eq("mid_rst_ready", bus.req_ready, 1'b1);
        check_eq("mid_rst_rsp", bus.rsp_valid, 1'b0);
        check_eq("mid_rst_enable", bus.exe_enable, 1'b0);
        check_eq("mid_rst_err_to", bus.err_timeout, 1'b0);
        check_eq("mid_rst_err_sp", bus.err_spurious, 1'b0);
        repeat (5) @(negedge clock);
        check_eq("post_rst_enable", bus.exe_enable, 1'b0);
        check_eq("post_rst_rsp", bus.rsp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
